// File: rtl/snow3g_pkg.sv
// SNOW 3G constants, GF(2^8) helpers and per-entry generators for the SR/SQ byte and MULa/DIVa word tables.
// All generators are evaluated at elaboration only; the hardware sees constant ROM contents.
package snow3g_pkg;

  localparam logic [7:0] MIX_SR     = 8'h1B;
  localparam logic [7:0] MIX_SQ     = 8'h69;
  localparam logic [7:0] ALPHA_POLY = 8'hA9;

  typedef enum logic {SBOX_SR, SBOX_SQ} sbox_sel_e;

  function automatic logic [7:0] mulx(input logic [7:0] v, input logic [7:0] c);
    return v[7] ? ({v[6:0], 1'b0} ^ c) : {v[6:0], 1'b0};
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = mulx(p, c);
    end
    return acc;
  endfunction

  // Square-and-multiply keeps every loop at 8 iterations, even for exponents like 245.
  function automatic logic [7:0] gf_pow(input logic [7:0] a, input logic [7:0] e,
                                        input logic [7:0] c);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h01;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) acc = gf_mul(acc, p, c);
      p = gf_mul(p, p, c);
    end
    return acc;
  endfunction

  function automatic logic [7:0] mulxpow(input logic [7:0] v, input logic [7:0] i,
                                         input logic [7:0] c);
    return gf_mul(v, gf_pow(8'h02, i, c), c);
  endfunction

  // AES S-box: x^254 (inverse, 0 -> 0) followed by the affine map.
  function automatic logic [7:0] sr_byte(input logic [7:0] x);
    logic [7:0] v;
    v = gf_pow(x, 8'd254, MIX_SR);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  // Dickson polynomial g49 over GF(2^8) mod x^8+x^6+x^5+x^3+1, offset by 0x25.
  function automatic logic [7:0] sq_byte(input logic [7:0] x);
    return x ^ gf_pow(x, 8'd9, MIX_SQ) ^ gf_pow(x, 8'd13, MIX_SQ) ^ gf_pow(x, 8'd15, MIX_SQ)
             ^ gf_pow(x, 8'd33, MIX_SQ) ^ gf_pow(x, 8'd41, MIX_SQ) ^ gf_pow(x, 8'd45, MIX_SQ)
             ^ gf_pow(x, 8'd47, MIX_SQ) ^ gf_pow(x, 8'd49, MIX_SQ) ^ 8'h25;
  endfunction

  function automatic logic [31:0] mula_word(input logic [7:0] c);
    return {mulxpow(c, 8'd23, ALPHA_POLY), mulxpow(c, 8'd245, ALPHA_POLY),
            mulxpow(c, 8'd48, ALPHA_POLY), mulxpow(c, 8'd239, ALPHA_POLY)};
  endfunction

  function automatic logic [31:0] diva_word(input logic [7:0] c);
    return {mulxpow(c, 8'd16, ALPHA_POLY), mulxpow(c, 8'd39, ALPHA_POLY),
            mulxpow(c, 8'd6, ALPHA_POLY), mulxpow(c, 8'd64, ALPHA_POLY)};
  endfunction

endpackage

// File: rtl/snow3g_sbox32.sv
// 32-bit SNOW 3G S-box: byte-wise table lookup (SR or SQ) followed by a MixColumn.
// Purely combinational, zero latency, no flow control.
module snow3g_sbox32
  import snow3g_pkg::*;
#(
  parameter sbox_sel_e        SEL = SBOX_SR,
  parameter logic      [7:0]  MIX = MIX_SR
) (
  input  logic [31:0] w,
  output logic [31:0] y
);

  logic [7:0] rom [256];

  for (genvar i = 0; i < 256; i++) begin : g_rom
    localparam logic [7:0] ENTRY = (SEL == SBOX_SQ) ? sq_byte(8'(i)) : sr_byte(8'(i));
    assign rom[i] = ENTRY;
  end

  logic [7:0] b0, b1, b2, b3;
  logic [7:0] d0, d1, d2, d3;

  assign b0 = rom[w[31:24]];
  assign b1 = rom[w[23:16]];
  assign b2 = rom[w[15:8]];
  assign b3 = rom[w[7:0]];

  assign d0 = mulx(b0, MIX);
  assign d1 = mulx(b1, MIX);
  assign d2 = mulx(b2, MIX);
  assign d3 = mulx(b3, MIX);

  // 3x is written as 2x ^ x.
  assign y[31:24] = d0 ^ b1 ^ b2 ^ (d3 ^ b3);
  assign y[23:16] = (d0 ^ b0) ^ d1 ^ b2 ^ b3;
  assign y[15:8]  = b0 ^ (d1 ^ b1) ^ d2 ^ b3;
  assign y[7:0]   = b0 ^ b1 ^ (d2 ^ b2) ^ d3;

endmodule

// File: rtl/snow3g_fsm_alpha_core.sv
// SNOW 3G FSM (R1/R2/R3) with output word F, plus the MULalpha/DIValpha LFSR feedback helpers.
// F and both alpha paths are combinational; state advances one cycle after en, no backpressure.
module snow3g_fsm_alpha_core
  import snow3g_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic [31:0] fsm_out,
  input  logic [31:0] alpha_in,
  output logic [31:0] alpha_out,
  input  logic [31:0] alpha_inv_in,
  output logic [31:0] alpha_inv_out
);

  logic [31:0] r1, r2, r3;
  logic [31:0] r1_d, r2_d, r3_d;
  logic [31:0] s1_w, s2_w;

  snow3g_sbox32 #(.SEL(SBOX_SR), .MIX(MIX_SR)) u_s1 (.w(r1), .y(s1_w));
  snow3g_sbox32 #(.SEL(SBOX_SQ), .MIX(MIX_SQ)) u_s2 (.w(r2), .y(s2_w));

  always_comb begin
    r1_d = r1;
    r2_d = r2;
    r3_d = r3;
    if (en) begin
      r1_d = r2 + (r3 ^ in2);
      r2_d = s1_w;
      r3_d = s2_w;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r1 <= '0;
      r2 <= '0;
      r3 <= '0;
    end else begin
      r1 <= r1_d;
      r2 <= r2_d;
      r3 <= r3_d;
    end
  end

  assign fsm_out = (in1 + r1) ^ r2;

  // Alpha tables are elaboration-time constants indexed by the byte shifted out.
  logic [31:0] mula_rom [256];
  logic [31:0] diva_rom [256];

  for (genvar i = 0; i < 256; i++) begin : g_alpha_rom
    localparam logic [31:0] MULA_E = mula_word(8'(i));
    localparam logic [31:0] DIVA_E = diva_word(8'(i));
    assign mula_rom[i] = MULA_E;
    assign diva_rom[i] = DIVA_E;
  end

  assign alpha_out     = {alpha_in[23:0], 8'h00} ^ mula_rom[alpha_in[31:24]];
  assign alpha_inv_out = {8'h00, alpha_inv_in[31:8]} ^ diva_rom[alpha_inv_in[7:0]];

endmodule

// File: tb/tb_snow3g_fsm_alpha_core.sv
// Randomized self-checking bench for snow3g_fsm_alpha_core against a behavioural SNOW 3G model.
module tb_snow3g_fsm_alpha_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] in1, in2;
  logic [31:0] fsm_out;
  logic [31:0] alpha_in, alpha_out;
  logic [31:0] alpha_inv_in, alpha_inv_out;

  int total = 0;
  int bad   = 0;

  snow3g_fsm_alpha_core dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .in1          (in1),
    .in2          (in2),
    .fsm_out      (fsm_out),
    .alpha_in     (alpha_in),
    .alpha_out    (alpha_out),
    .alpha_inv_in (alpha_inv_in),
    .alpha_inv_out(alpha_inv_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  sr_t   [256];
  logic [7:0]  sq_t   [256];
  logic [31:0] mula_t [256];
  logic [31:0] diva_t [256];
  logic [31:0] m_r1, m_r2, m_r3;

  function automatic logic [7:0] t_mulx(input logic [7:0] v, input logic [7:0] c);
    logic [7:0] s;
    s = v << 1;
    if (v[7]) s = s ^ c;
    return s;
  endfunction

  function automatic logic [7:0] t_mulxpow(input logic [7:0] v, input int n, input logic [7:0] c);
    logic [7:0] r;
    r = v;
    for (int k = 0; k < n; k++) r = t_mulx(r, c);
    return r;
  endfunction

  function automatic logic [7:0] t_gmul(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    logic [7:0] r;
    r = 8'h00;
    for (int k = 7; k >= 0; k--) begin
      r = t_mulx(r, c);
      if (b[k]) r = r ^ a;
    end
    return r;
  endfunction

  function automatic logic [7:0] t_sr(input logic [7:0] x);
    logic [7:0] inv, o, cst;
    inv = 8'h00;
    for (int b = 1; b < 256; b++)
      if (t_gmul(x, 8'(b), 8'h1B) == 8'h01) inv = 8'(b);
    cst = 8'h63;
    for (int i = 0; i < 8; i++)
      o[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ cst[i];
    return o;
  endfunction

  function automatic logic [7:0] t_sq(input logic [7:0] x);
    logic [7:0] p, acc;
    acc = 8'h25;
    p = x;
    for (int k = 1; k <= 49; k++) begin
      if (k == 1 || k == 9 || k == 13 || k == 15 || k == 33 || k == 41 || k == 45 || k == 47 || k == 49)
        acc = acc ^ p;
      p = t_gmul(p, x, 8'h69);
    end
    return acc;
  endfunction

  function automatic logic [31:0] t_s(input logic [31:0] w, input bit use_sq);
    logic [7:0] b [4];
    logic [7:0] o [4];
    logic [7:0] c;
    c = use_sq ? 8'h69 : 8'h1B;
    for (int j = 0; j < 4; j++) b[j] = use_sq ? sq_t[w[31-8*j -: 8]] : sr_t[w[31-8*j -: 8]];
    // Circulant MixColumn rows: 2,3,1,1 rotated per output byte.
    for (int j = 0; j < 4; j++)
      o[j] = t_mulx(b[j], c) ^ (t_mulx(b[(j+3)%4], c) ^ b[(j+3)%4]) ^ b[(j+1)%4] ^ b[(j+2)%4];
    return {o[0], o[1], o[2], o[3]};
  endfunction

  function automatic logic [31:0] m_alpha(input logic [31:0] x);
    return (x << 8) ^ mula_t[x[31:24]];
  endfunction

  function automatic logic [31:0] m_alpha_inv(input logic [31:0] x);
    return (x >> 8) ^ diva_t[x[7:0]];
  endfunction

  // Advance the model on the edge exactly as the DUT sees it, then sample 1 time unit later.
  task automatic tick();
    logic [31:0] nr;
    @(posedge clk);
    if (rst) begin
      m_r1 = 0; m_r2 = 0; m_r3 = 0;
    end else if (en) begin
      nr   = m_r2 + (m_r3 ^ in2);
      m_r3 = t_s(m_r2, 1'b1);
      m_r2 = t_s(m_r1, 1'b0);
      m_r1 = nr;
    end
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] x, a, b, y;
    for (int i = 0; i < 256; i++) begin
      sr_t[i]   = t_sr(8'(i));
      sq_t[i]   = t_sq(8'(i));
      mula_t[i] = {t_mulxpow(8'(i), 23, 8'hA9), t_mulxpow(8'(i), 245, 8'hA9),
                   t_mulxpow(8'(i), 48, 8'hA9), t_mulxpow(8'(i), 239, 8'hA9)};
      diva_t[i] = {t_mulxpow(8'(i), 16, 8'hA9), t_mulxpow(8'(i), 39, 8'hA9),
                   t_mulxpow(8'(i), 6, 8'hA9), t_mulxpow(8'(i), 64, 8'hA9)};
    end
    m_r1 = 'x; m_r2 = 'x; m_r3 = 'x;

    rst = 1; en = 0; in1 = 32'h12345678; in2 = 0; alpha_in = 0; alpha_inv_in = 0;
    tick();
    rst = 0;
    #1 chk("reset_fout", fsm_out, 32'h12345678);

    en = 1; in1 = 0; in2 = 32'hDEADBEEF;
    tick();
    chk("first_update", fsm_out, 32'hBDCEDD8C);
    chk("first_model", fsm_out, (in1 + m_r1) ^ m_r2);

    en = 0;
    for (int c = 0; c < 5; c++) begin
      in2 = $urandom;
      tick();
      chk("hold", fsm_out, 32'hBDCEDD8C);
    end
    // Both registers feeding F were held; the next enabled step exposes R3 via R1.
    en = 1; in2 = 0;
    tick();
    chk("post_hold_step", fsm_out, (in1 + m_r1) ^ m_r2);

    rst = 1; en = 1; in1 = 32'h12345678; in2 = $urandom;
    tick();
    chk("rst_over_en", fsm_out, 32'h12345678);
    rst = 0;

    // Two steps from zero: R2 = S1(in2) with all bytes 0x01 gives SR(0x01)=0x7C in every byte.
    in1 = 0; in2 = 32'h01010101;
    tick();
    in2 = 0;
    tick();
    chk("sr_anchor_r2", fsm_out ^ m_r1, 32'h7C7C7C7C);
    chk("anchor_model", fsm_out, (in1 + m_r1) ^ m_r2);

    for (int c = 0; c < 80; c++) begin
      rst = ($urandom_range(0, 24) == 0);
      en  = ($urandom_range(0, 3) != 0);
      in1 = $urandom;
      in2 = $urandom;
      tick();
      chk("fsm_rand", fsm_out, (in1 + m_r1) ^ m_r2);
      in1 = $urandom;
      #1 chk("fsm_comb_in1", fsm_out, (in1 + m_r1) ^ m_r2);
    end
    rst = 0;

    alpha_in = 32'h00FFFFFF;
    #1 chk("alpha_bound", alpha_out, 32'hFFFFFF00);
    alpha_inv_in = 32'hFFFFFF00;
    #1 chk("alpha_inv_bound", alpha_inv_out, 32'h00FFFFFF);
    alpha_in = 0; alpha_inv_in = 0;
    #1 chk("alpha_zero", alpha_out, 32'h0);
    chk("alpha_inv_zero", alpha_inv_out, 32'h0);

    for (int n = 0; n < 10000; n++) begin
      x = $urandom;
      alpha_in = x;
      #1;
      y = alpha_out;
      if (n < 600) chk("alpha_model", y, m_alpha(x));
      alpha_inv_in = y;
      #1 chk("alpha_roundtrip", alpha_inv_out, x);
      if (n < 600) begin
        alpha_inv_in = x;
        #1 chk("alpha_inv_model", alpha_inv_out, m_alpha_inv(x));
      end
    end

    for (int n = 0; n < 200; n++) begin
      a = $urandom; b = $urandom;
      alpha_in = a; alpha_inv_in = a;
      #1 x = alpha_out; y = alpha_inv_out;
      alpha_in = b; alpha_inv_in = b;
      #1 x = x ^ alpha_out; y = y ^ alpha_inv_out;
      alpha_in = a ^ b; alpha_inv_in = a ^ b;
      #1 chk("alpha_linear", alpha_out, x);
      chk("alpha_inv_linear", alpha_inv_out, y);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/snow3g_fsm_alpha_core.md
Name: snow3g_fsm_alpha_core

Overview:
SNOW 3G nonlinear core. Holds the three 32-bit FSM registers R1/R2/R3 and produces the FSM output word F. It also provides the two combinational GF(2^8)-based LFSR feedback multipliers, MULalpha and DIValpha, used by the enclosing LFSR/keystream block. The enclosing block owns the s0..s15 shift register and keystream XOR.

Parameters:
- none. All constants are fixed by the SNOW 3G specification.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: synchronous active-high reset; clears R1/R2/R3.
- en, input, 1: advance FSM state this cycle. When low, R1/R2/R3 hold.
- in1, input, 32: LFSR tap s15.
- in2, input, 32: LFSR tap s5.
- fsm_out, output, 32: F = (in1 + R1) XOR R2, combinational.
- alpha_in, input, 32: word to scale by alpha, normally s0.
- alpha_out, output, 32: (alpha_in << 8) XOR MULa(alpha_in[31:24]), combinational.
- alpha_inv_in, input, 32: word to scale by alpha^-1, normally s11.
- alpha_inv_out, output, 32: (alpha_inv_in >> 8) XOR DIVa(alpha_inv_in[7:0]), combinational.

Behaviour:
- Clocking: one clock domain; reset is synchronous and active-high. "+" means addition mod 2^32. Words are big-endian; byte 0 = bits [31:24].
- Reset: on a rising clk with rst=1, R1=R2=R3=0. This has priority over en. After reset, fsm_out = in1.
- Update on a rising clk with rst=0 and en=1, using pre-edge values throughout:
  - r = R2 + (R3 XOR in2)
  - R3 <= S2(R2)
  - R2 <= S1(R1)
  - R1 <= r
- en=0: all three registers hold.
- Latency: fsm_out has zero latency with respect to in1 and the current R1/R2. A change on in2 affects state only, one cycle later.
- MULx(V,c): if V[7]=1 then (V<<1)[7:0] XOR c, else V<<1.
- MULxPOW(V,i,c): apply MULx i times; i=0 gives V.
- MULa(c) = {MULxPOW(c,23,A9), MULxPOW(c,245,A9), MULxPOW(c,48,A9), MULxPOW(c,239,A9)}.
- DIVa(c) = {MULxPOW(c,16,A9), MULxPOW(c,39,A9), MULxPOW(c,6,A9), MULxPOW(c,64,A9)}.
- MULa and DIVa are 256x32 constant tables, ROM or generated at elaboration; they must not be iterated at runtime.
- S1(w): let b_k = SR(w_k), where SR is the AES S-box. Output bytes are a MixColumn with MULx constant 0x1B:
  - r0 = 2b0^b1^b2^3b3
  - r1 = 3b0^2b1^b2^b3
  - r2 = b0^3b1^2b2^b3
  - r3 = b0^b1^3b2^2b3
  - Here 2x = MULx(x,0x1B) and 3x = 2x^x.
- S2(w): same structure with SQ, the SNOW 3G Dickson S-box, and MULx constant 0x69.
- Properties that must hold:
  - alpha_inv_out(alpha_out(x)) = x for all x.
  - alpha and alpha_inv are GF(2)-linear.
  - alpha_out(0) = 0 and alpha_inv_out(0) = 0.
- No X propagation: all outputs are defined for any inputs after the first reset.

Decomposition:
- Package snow3g_pkg:
  - SR and SQ byte tables
  - MULa and DIVa word tables
  - MULx function
  - constants 0x1B, 0x69, 0xA9
- One sub-module, snow3g_sbox32, parameterized by table select (SR/SQ) and MixColumn constant. It is instantiated twice, as S1 and S2.
- alpha and alpha_inv are small combinational functions inside the top. They stay separate from the FSM registers.

Test Plan:
- Reset state: rst=1 for 1 cycle; in1=0x12345678, in2=0 -> fsm_out=0x12345678.
- First update: after reset, en=1, in1=0, in2=0xDEADBEEF, one clock -> R1=0xDEADBEEF, R2=0x63636363, R3=0x25252525. With in1=0, fsm_out = 0xDEADBEEF^0x63636363 = 0xBDCEDD8C.
- Hold and reset priority: en=0 for 5 cycles -> R1/R2/R3 and fsm_out unchanged. Then rst=1 with en=1 -> registers 0.
- Alpha boundaries: alpha_in=0x00FFFFFF -> alpha_out=0xFFFFFF00. alpha_inv_in=0xFFFFFF00 -> alpha_inv_out=0x00FFFFFF. Zero input -> zero output for both.
- Alpha inverse and linearity: 10k random x -> alpha_inv_out(alpha_out(x))==x. Random a,b -> alpha(a^b)==alpha(a)^alpha(b).
- Golden model: 33 cycles driven from a C SNOW 3G FSM model with ETSI key/IV vectors -> fsm_out matches the model every cycle.
